count_seq_checker: RTL and testbench



---
 rtl/count_seq_checker.sv | 158 +++++++++++++++
 tb/tb_count_seq_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// count_seq_checker
// Monitors a modulo counter's output bus, checks it against the legal sequence
// 0,1,..,MOD-1,0,.. and locks once LOCK_N consecutive increments are seen.
// Reports wraps, counts laps and flags faults. Upstream drives on negedge;
// this block samples on posedge.
//
// state  | meaning
// IDLE   | waiting for the first valid sample to seed prev
// SYNC   | counting consecutive correct increments towards lock
// LOCKED | sequence proven; wraps counted, faults and resyncs reported
// FAULT  | sticky fault; samples ignored until clr_err
module count_seq_checker #(
  parameter int CNT_W  = 3,
  parameter int MOD    = 8,
  parameter int LOCK_N = 2,
  parameter int LAP_W  = 8,
  parameter int ERR_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_cnt_in,
  input  logic             i_cnt_vld,
  input  logic             i_clr_err,
  output logic             o_locked,
  output logic             o_wrap_pulse,
  output logic             o_resync_pulse,
  output logic             o_err_pulse,
  output logic             o_err_flag,
  output logic [LAP_W-1:0] o_lap_count,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int MC_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MOD - 1);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_prev, w_prev_nxt;
  logic [MC_W-1:0]  r_match_cnt, w_match_cnt_nxt;
  logic             r_locked, r_wrap, r_resync, r_err, r_err_flag;
  logic             w_wrap_nxt, w_resync_nxt, w_err_nxt, w_err_flag_nxt;
  logic [LAP_W-1:0] r_lap, w_lap_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

  logic [CNT_W-1:0] w_exp;
  logic [MC_W-1:0]  w_mc_inc;
  logic             w_in_range;
  logic             w_match;

  // Expected next value and match decision; out-of-range inputs never match
  always_comb begin
    w_exp      = (r_prev == LAST) ? '0 : r_prev + CNT_W'(1);
    w_in_range = (int'(i_cnt_in) < MOD);
    w_match    = w_in_range && (i_cnt_in == w_exp);
    w_mc_inc   = r_match_cnt + MC_W'(1);
  end

  // Next-state and next-output logic; all outputs are registered from these
  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_match_cnt_nxt = r_match_cnt;
    w_wrap_nxt      = 1'b0;
    w_resync_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_flag_nxt  = r_err_flag;
    w_lap_nxt       = r_lap;
    w_err_cnt_nxt   = r_err_cnt;
    case (r_state)
      IDLE: begin
        if (i_cnt_vld) begin
          w_prev_nxt      = i_cnt_in;
          w_match_cnt_nxt = '0;
          w_state_nxt     = SYNC;
        end
      end
      SYNC: begin
        if (i_cnt_vld) begin
          w_prev_nxt = i_cnt_in;
          if (w_match) begin
            w_match_cnt_nxt = w_mc_inc;
            if (w_mc_inc == MC_LOCK) w_state_nxt = LOCKED;
          end else begin
            w_match_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (i_cnt_vld) begin
          if (w_match) begin
            w_prev_nxt = i_cnt_in;
            if (r_prev == LAST) begin
              w_wrap_nxt = 1'b1;
              w_lap_nxt  = r_lap + LAP_W'(1);
            end
          end else if (i_cnt_in == '0) begin
            // Upstream counter was reset: re-prove the sequence without faulting
            w_resync_nxt    = 1'b1;
            w_prev_nxt      = '0;
            w_match_cnt_nxt = '0;
            w_state_nxt     = SYNC;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_flag_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
            w_state_nxt    = FAULT;
          end
        end
      end
      FAULT: begin
        // Clear wins over a coincident sample, which is simply dropped
        if (i_clr_err) begin
          w_err_flag_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
      r_wrap      <= 1'b0;
      r_resync    <= 1'b0;
      r_err       <= 1'b0;
      r_err_flag  <= 1'b0;
      r_lap       <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_wrap      <= w_wrap_nxt;
      r_resync    <= w_resync_nxt;
      r_err       <= w_err_nxt;
      r_err_flag  <= w_err_flag_nxt;
      r_lap       <= w_lap_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign o_locked       = r_locked;
  assign o_wrap_pulse   = r_wrap;
  assign o_resync_pulse = r_resync;
  assign o_err_pulse    = r_err;
  assign o_err_flag     = r_err_flag;
  assign o_lap_count    = r_lap;
  assign o_err_count    = r_err_cnt;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with default parameters.
module tb_count_seq_checker;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [2:0] i_cnt_in = '0;
  logic       i_cnt_vld = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       o_locked, o_wrap_pulse, o_resync_pulse, o_err_pulse, o_err_flag;
  logic [7:0] o_lap_count;
  logic [3:0] o_err_count;

  int tests = 0;
  int fails = 0;

  count_seq_checker #(.CNT_W(3), .MOD(8), .LOCK_N(2), .LAP_W(8), .ERR_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cnt_in(i_cnt_in), .i_cnt_vld(i_cnt_vld),
    .i_clr_err(i_clr_err), .o_locked(o_locked), .o_wrap_pulse(o_wrap_pulse),
    .o_resync_pulse(o_resync_pulse), .o_err_pulse(o_err_pulse), .o_err_flag(o_err_flag),
    .o_lap_count(o_lap_count), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on negedge like the upstream counter, observe just after posedge
  task automatic step(input logic v, input logic [2:0] c, input logic clr);
    @(negedge i_clk);
    i_cnt_vld = v; i_cnt_in = c; i_clr_err = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic w, input logic r, input logic e);
    chk({tag, "_wrap"}, o_wrap_pulse, w);
    chk({tag, "_resync"}, o_resync_pulse, r);
    chk({tag, "_err"}, o_err_pulse, e);
  endtask

  initial begin
    int p;
    int v;
    int wraps;
    int n;
    logic [7:0] exp_lap;
    logic [3:0] exp_errc;
    logic vld;

    // Reset state
    #12;
    chk("rst_locked", o_locked, 0);
    chk("rst_flag", o_err_flag, 0);
    chk("rst_lap", o_lap_count, 0);
    chk("rst_errc", o_err_count, 0);
    chk_pulses("rst", 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 1: 0..7,0,1 -> lock on third sample, one wrap after the second 0
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i % 8), 1'b0);
      chk($sformatf("t1_locked_%0d", i), o_locked, (i >= 2));
      chk($sformatf("t1_wrap_%0d", i), o_wrap_pulse, (i == 8));
    end
    chk("t1_lap", o_lap_count, 1);
    chk("t1_errc", o_err_count, 0);

    // 2: continue 2..5, then jump to 0 -> resync, relock after 1,2
    for (int i = 2; i <= 5; i++) begin
      step(1'b1, 3'(i), 1'b0);
      chk("t2_locked_run", o_locked, 1);
    end
    step(1'b1, 3'd0, 1'b0);
    chk("t2_resync_locked", o_locked, 0);
    chk_pulses("t2_resync", 0, 1, 0);
    chk("t2_resync_flag", o_err_flag, 0);
    step(1'b1, 3'd1, 1'b0);
    chk("t2_s1_locked", o_locked, 0);
    chk_pulses("t2_s1", 0, 0, 0);
    step(1'b1, 3'd2, 1'b0);
    chk("t2_s2_locked", o_locked, 1);
    chk("t2_errc", o_err_count, 0);

    // 3: skip 3->5 faults; samples ignored; clr_err returns to IDLE
    step(1'b1, 3'd3, 1'b0);
    chk("t3_pre_locked", o_locked, 1);
    step(1'b1, 3'd5, 1'b0);
    chk("t3_err_locked", o_locked, 0);
    chk_pulses("t3_err", 0, 0, 1);
    chk("t3_err_flag", o_err_flag, 1);
    chk("t3_err_cnt", o_err_count, 1);
    step(1'b1, 3'd6, 1'b0);
    chk("t3_ign_pulse", o_err_pulse, 0);
    chk("t3_ign_flag", o_err_flag, 1);
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    chk("t3_ign_locked", o_locked, 0);
    chk_pulses("t3_ign", 0, 0, 0);
    step(1'b0, 3'd0, 1'b1);
    chk("t3_clr_flag", o_err_flag, 0);
    chk("t3_clr_errc", o_err_count, 1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    chk("t3_relock1", o_locked, 0);
    step(1'b1, 3'd2, 1'b0);
    chk("t3_relock2", o_locked, 1);
    step(1'b1, 3'd3, 1'b1);
    chk("t3_clr_locked_noeffect", o_locked, 1);
    chk("t3_clr_locked_flag", o_err_flag, 0);
    step(1'b0, 3'd5, 1'b0);
    chk("t3_gap_locked", o_locked, 1);
    chk_pulses("t3_gap", 0, 0, 0);
    step(1'b1, 3'd4, 1'b0);
    chk("t3_after_gap", o_locked, 1);
    p = 4;

    // 4: 20 hold faults; error count saturates at 15; clear+sample drops the sample
    exp_errc = 4'd1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 3'(p), 1'b0);
      if (exp_errc != 4'hf) exp_errc = exp_errc + 4'd1;
      chk($sformatf("t4_err_%0d", k), o_err_pulse, 1);
      chk($sformatf("t4_errc_%0d", k), o_err_count, exp_errc);
      if (k == 5) begin
        step(1'b1, 3'd0, 1'b1);
        chk("t4_combo_flag", o_err_flag, 0);
        chk("t4_combo_locked", o_locked, 0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        chk("t4_combo_dropped", o_locked, 0);
        step(1'b1, 3'd3, 1'b0);
        chk("t4_combo_relock", o_locked, 1);
        p = 3;
      end else begin
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        chk($sformatf("t4_relock_%0d", k), o_locked, 1);
        p = 2;
      end
    end
    chk("t4_errc_sat", o_err_count, 15);

    // 5: random gaps in a legal sequence; 256 wraps roll lap_count through 255->0
    exp_lap = 8'd1;
    wraps = 0;
    v = p;
    n = 0;
    while (n < 4000 && wraps < 256) begin
      vld = ($urandom_range(0, 3) != 0);
      if (vld) begin
        v = (v + 1) % 8;
        step(1'b1, 3'(v), 1'b0);
        if (v == 0) begin
          exp_lap = exp_lap + 8'd1;
          wraps++;
          chk("t5_wrap", o_wrap_pulse, 1);
          chk("t5_lap", o_lap_count, exp_lap);
        end else begin
          chk("t5_nowrap", o_wrap_pulse, 0);
        end
      end else begin
        step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
        chk("t5_gap_wrap", o_wrap_pulse, 0);
      end
      chk("t5_locked", o_locked, 1);
      n++;
    end
    chk("t5_wrap_budget", wraps, 256);
    chk("t5_lap_final", o_lap_count, 1);

    // 6: async reset mid-LOCKED, between edges
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_locked", o_locked, 0);
    chk("t6_lap", o_lap_count, 0);
    chk("t6_errc", o_err_count, 0);
    chk("t6_flag", o_err_flag, 0);
    chk_pulses("t6", 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1'b1, 3'd0, 1'b0);
    chk("t6_post_locked", o_locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
